reg_cpu_regbank: RTL
====================

# reg_cpu_regbank

Parametrised register-bank slave on the reg_cpu bus: decodes a CPU access, writes or reads one of NUM_REGS DW-bit registers after a programmable latency, and responds with wack/rdv plus a new error flag. It extends the plain reg_cpu handshake with byte enables, per-register read-only status mapping, and out-of-range/misuse error reporting. It sits between the reg_cpu master (TB driver or CPU bridge) and the image-pipe datapath control/status.

## Interface
- DW, 32, data width; multiple of 8.
- AW, 32, byte-address width.
- NUM_REGS, 16, number of registers; 1..256.
- BASE_ADDR, 0, byte address of register 0; DW/8-aligned.
- LAT, 1, cycles from accept to response; 1..15.
- RO_MASK, 0, NUM_REGS bits; bit i=1 makes register i read-only (reads return reg_hw_d slice i).

Ports:
- reg_cpu_clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- reg_cpu_cs  in  1  chip select / request valid.
- reg_cpu_addr  in  AW  byte address.
- reg_cpu_data_wr  in  DW  write data.
- reg_cpu_be  in  DW/8  byte enables (only with REG_CPU_REGBANK_BE_EN).
- reg_cpu_we  in  1  write request.
- reg_cpu_re  in  1  read request.
- reg_cpu_data_rd  out  DW  read data.
- reg_cpu_wack  out  1  write acknowledge pulse.
- reg_cpu_rdv  out  1  read-data-valid pulse.
- reg_cpu_err  out  1  error qualifier, valid only with wack/rdv.
- reg_q  out  NUM_REGS*DW  current register contents, reg i at [i*DW +: DW].
- reg_hw_d  in  NUM_REGS*DW  hardware status for RO registers.
- reg_wr_pulse  out  NUM_REGS  one-cycle strobe on the commit edge of a successful write to reg i.

## Operation
- Index = (addr − BASE_ADDR) >> log2(DW/8). Decode error: addr < BASE_ADDR, index ≥ NUM_REGS, or addr not DW/8-aligned.
- FSM IDLE → BUSY → RESP → DRAIN → IDLE.
- IDLE: accept when cs=1 and (we|re)=1. Capture addr, data_wr, be, we, re. Go BUSY with counter=LAT−1; if LAT=1 go directly to RESP.
- BUSY: decrement; at 0 go RESP.
- RESP (one cycle): drive exactly one of wack (write or we&re) or rdv (read only).
  - Write, no error, writable reg: commit enabled bytes to reg i, pulse reg_wr_pulse[i].
  - Write to RO reg: no commit, err=1, no pulse.
  - we&re both set at accept: treated as write with err=1, no commit.
  - Read: data_rd = RO_MASK[i] ? reg_hw_d slice : reg_q slice, sampled in RESP; err=1 and data_rd=0 on decode error.
- DRAIN: wait until cs=0, then IDLE. A held cs never causes re-acceptance.
- cs=1 with we=re=0 in IDLE: ignored, stays IDLE.
- RO register storage in reg_q stays at reset value 0.

## Timing
- Reset (async assert, sync-release assumed upstream): state IDLE, reg_q all 0, data_rd 0, wack/rdv/err 0, reg_wr_pulse 0.
- Accept at edge N; wack/rdv/err high for the cycle after edge N+LAT−1, i.e. registered outputs asserted from edge N+LAT−1... exactly LAT edges after accept the pulse is visible, for exactly one cycle.
- Write commit and reg_wr_pulse occur on the same edge that raises wack; reg_q shows new value in the wack cycle.
- data_rd holds its value until the next rdv; not cleared by writes.
- Earliest next accept: first edge with cs=0 seen in DRAIN + 1 edge.
- Reset asserted mid-transaction: transaction dropped, no response, no commit.
- Inputs other than cs/we/re ignored outside IDLE.

## Configuration
- REG_CPU_REGBANK_BE_EN defined: reg_cpu_be port present; only bytes with be[k]=1 are written; be=0 write still gives wack, err=0, reg_wr_pulse asserted, no data change.
- Undefined: no reg_cpu_be port; every write updates all DW/8 bytes.

## Test plan
- Reset, read reg 3 (addr 0x0C), LAT=1 -> rdv one cycle after accept, data_rd=0, err=0.
- Write 0xDEADBEEF to reg 5, read back, LAT=4 -> wack 4 edges after accept, reg_wr_pulse[5] same edge, readback 0xDEADBEEF.
- With BE_EN: write 0xFFFFFFFF be=4'b0101 to reg 2 holding 0 -> reg 2 = 0x00FF00FF.
- RO_MASK bit 7, reg_hw_d slice 7=0x1234: write reg 7 -> wack err=1, no pulse; read -> 0x1234 err=0.
- Read addr 0x40 (NUM_REGS=16) and addr 0x02 -> rdv err=1, data_rd=0 each; we&re together -> wack err=1.
- Hold cs/re high for 5 cycles after rdv -> only one rdv; assert rst_n=0 in BUSY -> no response, reg_q unchanged.

Source files
------------

// File: rtl/reg_cpu_regbank.sv
// reg_cpu_regbank: register-bank slave on the reg_cpu bus with programmable latency.
// Optional byte enables with REG_CPU_REGBANK_BE_EN (adds the reg_cpu_be port).
module reg_cpu_regbank #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int NUM_REGS  = 16,
    parameter int BASE_ADDR = 0,
    parameter int LAT       = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                   reg_cpu_clk,
    input  logic                   rst_n,
    input  logic                   reg_cpu_cs,
    input  logic [AW-1:0]          reg_cpu_addr,
    input  logic [DW-1:0]          reg_cpu_data_wr,
`ifdef REG_CPU_REGBANK_BE_EN
    input  logic [DW/8-1:0]        reg_cpu_be,
`endif
    input  logic                   reg_cpu_we,
    input  logic                   reg_cpu_re,
    output logic [DW-1:0]          reg_cpu_data_rd,
    output logic                   reg_cpu_wack,
    output logic                   reg_cpu_rdv,
    output logic                   reg_cpu_err,
    output logic [NUM_REGS*DW-1:0] reg_q,
    input  logic [NUM_REGS*DW-1:0] reg_hw_d,
    output logic [NUM_REGS-1:0]    reg_wr_pulse
);

    localparam int NB = DW / 8;
    localparam int LG = (NB > 1) ? $clog2(NB) : 0;
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [AW-1:0] BASE  = AW'(BASE_ADDR);
    localparam logic [AW-1:0] ALIGN = AW'(NB - 1);
    localparam logic [AW-1:0] NR    = AW'(NUM_REGS);
    localparam logic [3:0]    CNT_INIT = 4'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept;
    logic       in_resp;

    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wd;
    logic [NB-1:0] cap_be;
    logic          cap_we;
    logic          cap_re;

    logic [AW-1:0] off;
    logic [AW-1:0] off_idx;
    logic [IW-1:0] sel;
    logic          dec_err;
    logic          ro_hit;
    logic          commit;
    logic [DW-1:0] rd_val;

    logic [DW-1:0] regs [NUM_REGS];

    // FSM state and latency counter register
    always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: accept in IDLE, count latency, one RESP cycle, drain held cs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (reg_cpu_cs && (reg_cpu_we || reg_cpu_re)) begin
                    accept = 1'b1;
                    if (LAT <= 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!reg_cpu_cs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_resp = (state_q == S_RESP);

    // Request capture; bus inputs are only looked at while idle
    always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_addr <= '0;
            cap_wd   <= '0;
            cap_we   <= 1'b0;
            cap_re   <= 1'b0;
        end else if (accept) begin
            cap_addr <= reg_cpu_addr;
            cap_wd   <= reg_cpu_data_wr;
            cap_we   <= reg_cpu_we;
            cap_re   <= reg_cpu_re;
        end
    end

`ifdef REG_CPU_REGBANK_BE_EN
    // Byte-enable capture alongside the request
    always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_be <= '0;
        end else if (accept) begin
            cap_be <= reg_cpu_be;
        end
    end
`else
    assign cap_be = '1;
`endif

    assign off     = cap_addr - BASE;
    assign off_idx = off >> LG;
    assign sel     = off_idx[IW-1:0];
    assign dec_err = (cap_addr < BASE)
                   | ((off & ALIGN) != '0)
                   | (off_idx >= NR);
    assign ro_hit  = !dec_err && RO_MASK[sel];
    assign commit  = in_resp && cap_we && !cap_re
                   && !dec_err && !ro_hit;

    // Read mux: RO registers reflect hardware status, others the stored value
    always_comb begin
        rd_val = '0;
        if (!dec_err) begin
            if (RO_MASK[sel]) begin
                rd_val = reg_hw_d[int'(sel)*DW +: DW];
            end else begin
                rd_val = regs[sel];
            end
        end
    end

    // Response pulses; data_rd only changes on a read response
    always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_cpu_wack    <= 1'b0;
            reg_cpu_rdv     <= 1'b0;
            reg_cpu_err     <= 1'b0;
            reg_cpu_data_rd <= '0;
            reg_wr_pulse    <= '0;
        end else begin
            reg_cpu_wack <= 1'b0;
            reg_cpu_rdv  <= 1'b0;
            reg_cpu_err  <= 1'b0;
            reg_wr_pulse <= '0;
            if (in_resp) begin
                if (cap_we) begin
                    reg_cpu_wack <= 1'b1;
                    reg_cpu_err  <= dec_err | cap_re | ro_hit;
                end else begin
                    reg_cpu_rdv     <= 1'b1;
                    reg_cpu_err     <= dec_err;
                    reg_cpu_data_rd <= rd_val;
                end
                if (commit) begin
                    reg_wr_pulse <= NUM_REGS'(1) << sel;
                end
            end
        end
    end

    // Register file: commit enabled bytes of a successful write
    always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            for (int k = 0; k < NB; k++) begin
                if (cap_be[k]) begin
                    regs[sel][8*k +: 8] <= cap_wd[8*k +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign reg_q[g*DW +: DW] = regs[g];
    end

endmodule
